nibble_carry_seq: RTL and testbench
===================================

Name: nibble_carry_seq

Overview:
Nibble-serial carry sequencer for WIDTH-bit addition. Each cycle it processes one 4-bit nibble. It produces that nibble's propagate vector and carry vector, and these drive the 4-bit XOR sum stage directly downstream. It captures the returned sum nibble and chains the nibble carry-out in a register. After NIB cycles it presents the full WIDTH-bit result and the final carry-out.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and >= 4.
NIB, WIDTH/4, nibble count; derived, not overridable.
IW, max(1,$clog2(NIB)), nibble index width; derived.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  request; sampled only in IDLE.
a  in  WIDTH  operand A; sampled with start.
b  in  WIDTH  operand B; sampled with start.
cin  in  1  carry-in; sampled with start.
p_out  out  4  propagate nibble (a_n ^ b_n) to sum stage.
c_out  out  4  per-bit carry-in nibble to sum stage.
s_in  in  4  sum nibble returned from sum stage (p_out ^ c_out).
nib_valid  out  1  high in RUN; p_out, c_out and nib_idx are valid.
nib_idx  out  IW  current nibble index, 0 = least significant.
busy  out  1  high in RUN and DONE.
done  out  1  single-cycle pulse in DONE.
result  out  WIDTH  assembled sum; holds until next accepted start.
cout  out  1  final carry-out; holds with result.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - Operand registers, carry register, idx, result, cout = 0.
  - busy, done and nib_valid = 0.
  - p_out and c_out = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start = 1, latch a, b and cin; carry_reg <= cin; idx <= 0; go to RUN.
  - If start = 0, hold.
- RUN (combinational from registers only, no path from start, a or b):
  - pn = A[4*idx+:4] ^ B[4*idx+:4].
  - gn = A[4*idx+:4] & B[4*idx+:4].
  - c[0] = carry_reg.
  - c[i+1] = gn[i] | (pn[i] & c[i]) for i = 0..2.
  - p_out = pn, c_out = c, nib_valid = 1, nib_idx = idx.
  - nib_co = gn[3] | (pn[3] & c[3]).
- RUN edge actions:
  - result[4*idx+:4] <= s_in.
  - carry_reg <= nib_co.
  - If idx == NIB-1: cout <= nib_co, go to DONE.
  - Otherwise idx <= idx+1.
- DONE: done = 1 for exactly one cycle, then go to IDLE. result and cout are stable from this cycle on.
- Latency: start accepted at edge T. Nibbles are presented in cycles T+1..T+NIB, done is high in cycle T+NIB+1, and IDLE is reached at T+NIB+2.
- Back-to-back: start high in the first IDLE cycle after DONE is accepted. Start is not accepted in the DONE cycle itself.
- Outside RUN: p_out = 0, c_out = 0, nib_valid = 0, nib_idx = 0.
- Start held high during RUN or DONE is ignored. Changes to a, b or cin after acceptance have no effect.
- result is not cleared on start. Nibbles are overwritten in order, and result is valid only from done onward.
- NIB = 1: single RUN cycle, nib_idx fixed at 0.
- Reset mid-operation: all outputs go to their reset values immediately, the partial result is discarded, and the next start behaves normally.

Test Plan:
- All tests use WIDTH = 16, with a sum stage instantiated on p_out/c_out -> s_in.
- Carry ripple across all nibbles: a=0xFFFF, b=0x0001, cin=0 -> nibble 0 has p_out=4'b1110, c_out=4'b1110; nibbles 1-3 have p_out=4'b1111, c_out=4'b1111; result=0x0000, cout=1; done in cycle T+5.
- No carries: a=0x1234, b=0x4321, cin=0 -> c_out=0 on every nibble, nib_idx steps 0,1,2,3, result=0x5555, cout=0, done pulse exactly 1 cycle wide.
- Carry-in and MSB overflow: a=0x8000, b=0x8000, cin=1 -> nibble 0 has c_out=4'b0001; result=0x0001, cout=1.
- Start handling:
  - Hold start=1 throughout the 0x1234+0x4321 op while changing a/b mid-run -> result still 0x5555.
  - Keep start=1 through DONE -> a second op is accepted in the first IDLE cycle, and busy drops for exactly one cycle.
- Reset mid-operation: drive rst_n low while nib_idx=2 -> busy, nib_valid, done, result, cout, p_out and c_out are 0 within the same cycle, without waiting for a clock edge. After release, a=0x00FF, b=0x0001, cin=0 gives result=0x0100, cout=0.

Source files
------------

// File: rtl/nibble_carry_seq.sv
// nibble_carry_seq: nibble-serial WIDTH-bit adder sequencer; start/a/b/cin in, p_out/c_out to XOR sum stage, s_in back, result/cout/done/busy/nib_valid/nib_idx out
module nibble_carry_seq #(
  parameter int WIDTH = 16,
  localparam int NIB = WIDTH / 4,
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [3:0]       p_out,
  output logic [3:0]       c_out,
  input  logic [3:0]       s_in,
  output logic             nib_valid,
  output logic [IW-1:0]    nib_idx,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] op_a, op_b;
  logic carry_reg;
  logic [IW-1:0] idx;
  logic [3:0] pn, gn;
  logic [4:0] c;
  logic run;
  assign run = state == RUN;
  assign pn = op_a[4*idx+:4] ^ op_b[4*idx+:4];
  assign gn = op_a[4*idx+:4] & op_b[4*idx+:4];
  always_comb begin
    c[0] = carry_reg;
    for (int i = 0; i < 4; i++) c[i+1] = gn[i] | (pn[i] & c[i]);
  end
  assign p_out = run ? pn : 4'd0;
  assign c_out = run ? c[3:0] : 4'd0;
  assign nib_valid = run;
  assign nib_idx = run ? idx : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a <= '0;
      op_b <= '0;
      carry_reg <= 1'b0;
      idx <= '0;
      result <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_a <= a;
          op_b <= b;
          carry_reg <= cin;
          idx <= '0;
          state <= RUN;
        end
        RUN: begin
          result[4*idx+:4] <= s_in;
          carry_reg <= c[4];
          if (idx == IW'(NIB - 1)) begin
            cout <= c[4];
            state <= DONE;
          end else idx <= idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_carry_seq.sv
// tb_nibble_carry_seq: directed and random checks of nibble_carry_seq against an arithmetic reference model
module tb_nibble_carry_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic cin = 1'b0;
  logic [3:0] p_out, c_out, s_in;
  logic nib_valid, busy, done, cout;
  logic [1:0] nib_idx;
  logic [15:0] result;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  assign s_in = p_out ^ c_out;
  nibble_carry_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .p_out(p_out), .c_out(c_out), .s_in(s_in), .nib_valid(nib_valid),
    .nib_idx(nib_idx), .busy(busy), .done(done), .result(result), .cout(cout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] ref_c(input logic [15:0] x, input logic [15:0] y, input logic ci, input int n);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      int k = 4 * n + i;
      int unsigned m = (32'd1 << k) - 1;
      int unsigned s = (x & m) + (y & m) + ci;
      r[i] = s[k];
    end
    return r;
  endfunction
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic ci, input bit hold, input bit mutate);
    logic [16:0] sum;
    sum = 17'(x) + 17'(y) + 17'(ci);
    a = x;
    b = y;
    cin = ci;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      chk("nib_valid", nib_valid, 1);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("nib_idx", nib_idx, n);
      chk("p_out", p_out, x[4*n+:4] ^ y[4*n+:4]);
      chk("c_out", c_out, ref_c(x, y, ci, n));
      if (mutate) begin
        a = ~a;
        b = b + 16'h1111;
        cin = ~cin;
      end
    end
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("nib_valid_done", nib_valid, 0);
    chk("result", result, sum[15:0]);
    chk("cout", cout, sum[16]);
    @(posedge clk); #1;
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    chk("p_idle", p_out, 0);
    chk("c_idle", c_out, 0);
    chk("result_hold", result, sum[15:0]);
    chk("cout_hold", cout, sum[16]);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", nib_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_p", p_out, 0);
    chk("rst_c", c_out, 0);
    chk("rst_idx", nib_idx, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("idle_hold", busy, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 0);
    run_op(16'h1234, 16'h4321, 1'b0, 0, 0);
    run_op(16'h8000, 16'h8000, 1'b1, 0, 0);
    run_op(16'h1234, 16'h4321, 1'b0, 1, 1);
    run_op(16'hA5A5, 16'h5A5B, 1'b1, 1, 0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 0, 0);
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_idx", nib_idx, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", nib_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_p", p_out, 0);
    chk("mid_rst_c", c_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 0);
    for (int t = 0; t < 24; t++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    start = 1'b0;
    @(posedge clk); #1;
    chk("final_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
